// File: rtl/clock_pkg.sv
// Shared definitions for the clock slice: field limits, request source
// indices and the alarm state encoding.
package clock_pkg;

    localparam logic [5:0]  SEC_MAX = 6'd59;
    localparam logic [5:0]  MIN_MAX = 6'd59;
    localparam int unsigned NUM_SRC = 6;

    // Source index doubles as priority: lower index wins the grant.
    typedef enum logic [2:0] {
        SRC_TICK = 3'd0,
        SRC_SEC  = 3'd1,
        SRC_MIN  = 3'd2,
        SRC_HRS  = 3'd3,
        SRC_AL   = 3'd4,
        SRC_TOG  = 3'd5
    } src_e;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2
    } alarm_state_t;

    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? '0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/alarm_fsm.sv
// Alarm arming/ringing state machine with auto-silence ring counter.
// Driven purely by commit strobes and before/after match flags from the top.
module alarm_fsm
    import clock_pkg::*;
#(
    parameter int unsigned ALARM_TIMEOUT_S = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_commit,
    input  logic tog_commit,
    input  logic time_commit,
    input  logic match_before,
    input  logic match_after,
    output logic al_on,
    output logic alarm
);

    alarm_state_t state;
    logic [5:0]   ring_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= OFF;
            ring_cnt <= '0;
            al_on    <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    if (tog_commit) begin
                        state <= ARMED;
                        al_on <= 1'b1;
                    end
                end
                ARMED: begin
                    if (tog_commit) begin
                        state <= OFF;
                        al_on <= 1'b0;
                    end else if (time_commit && !match_before && match_after) begin
                        state    <= RINGING;
                        alarm    <= 1'b1;
                        ring_cnt <= '0;
                    end
                end
                RINGING: begin
                    if (tog_commit) begin
                        state <= OFF;
                        al_on <= 1'b0;
                        alarm <= 1'b0;
                    end else if (tick_commit) begin
                        // The tick that caused entry is not counted; this is the Nth tick after it.
                        if (ring_cnt == 6'(ALARM_TIMEOUT_S - 1)) begin
                            state <= ARMED;
                            alarm <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 6'd1;
                        end
                    end
                end
                default: begin
                    state <= OFF;
                    al_on <= 1'b0;
                    alarm <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/timekeep_scheduler.sv
// Time/alarm register owner: latches tick and button requests as pending,
// grants one per cycle by fixed priority and commits the field update.
module timekeep_scheduler
    import clock_pkg::*;
#(
    parameter int unsigned AL_STEP         = 10,
    parameter int unsigned HOURS_MAX       = 12,
    parameter int unsigned ALARM_TIMEOUT_S = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       sec_adj,
    input  logic       min_adj,
    input  logic       hrs_adj,
    input  logic       al_adj,
    input  logic       al_toggle,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [3:0] hours,
    output logic [5:0] al_minutes,
    output logic [3:0] al_hours,
    output logic       al_on,
    output logic       alarm,
    output logic       dropped
);

    logic [NUM_SRC-1:0] pulses;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] grant;

    logic [5:0] sec_n, min_n, alm_n;
    logic [3:0] hrs_n, alh_n;
    logic       match_before, match_after;

    function automatic logic [3:0] hr_inc(input logic [3:0] h);
        return (h == 4'(HOURS_MAX - 1)) ? 4'd0 : h + 4'd1;
    endfunction

    assign pulses = {al_toggle, al_adj, hrs_adj, min_adj, sec_adj, tick_1hz};

    // Isolate the lowest set bit: index 0 (TICK) has the highest priority.
    assign grant = pending & (~pending + NUM_SRC'(1));

    always_comb begin
        sec_n = seconds;
        min_n = minutes;
        hrs_n = hours;
        alm_n = al_minutes;
        alh_n = al_hours;
        if (grant[SRC_TICK]) begin
            sec_n = inc_wrap(seconds, SEC_MAX);
            if (seconds == SEC_MAX) begin
                min_n = inc_wrap(minutes, MIN_MAX);
                if (minutes == MIN_MAX) begin
                    hrs_n = hr_inc(hours);
                end
            end
        end
        if (grant[SRC_SEC]) begin
            sec_n = inc_wrap(seconds, SEC_MAX);
        end
        if (grant[SRC_MIN]) begin
            min_n = inc_wrap(minutes, MIN_MAX);
        end
        if (grant[SRC_HRS]) begin
            hrs_n = hr_inc(hours);
        end
        if (grant[SRC_AL]) begin
            if (al_minutes == 6'(60 - AL_STEP)) begin
                alm_n = '0;
                alh_n = hr_inc(al_hours);
            end else begin
                alm_n = al_minutes + 6'(AL_STEP);
            end
        end
    end

    assign match_before = (hours == al_hours) && (minutes == al_minutes);
    assign match_after  = (hrs_n == alh_n) && (min_n == alm_n);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            dropped    <= 1'b0;
            seconds    <= '0;
            minutes    <= '0;
            hours      <= '0;
            al_minutes <= '0;
            al_hours   <= '0;
        end else begin
            pending    <= (pending & ~grant) | pulses;
            dropped    <= dropped | (|(pulses & pending & ~grant));
            seconds    <= sec_n;
            minutes    <= min_n;
            hours      <= hrs_n;
            al_minutes <= alm_n;
            al_hours   <= alh_n;
        end
    end

    alarm_fsm #(
        .ALARM_TIMEOUT_S(ALARM_TIMEOUT_S)
    ) u_alarm_fsm (
        .clk          (clk),
        .reset        (reset),
        .tick_commit  (grant[SRC_TICK]),
        .tog_commit   (grant[SRC_TOG]),
        .time_commit  (|grant[SRC_AL:SRC_TICK]),
        .match_before (match_before),
        .match_after  (match_after),
        .al_on        (al_on),
        .alarm        (alarm)
    );

endmodule

// File: tb/tb_timekeep_scheduler.sv
// Scoreboard bench: a behavioural model predicts outputs after every edge,
// a negedge monitor pops and compares against the DUT.
module tb_timekeep_scheduler;

    localparam int AL_STEP   = 10;
    localparam int HM        = 12;
    localparam int TIMEOUT_S = 60;

    logic       clk;
    logic       reset;
    logic       tick_1hz, sec_adj, min_adj, hrs_adj, al_adj, al_toggle;
    logic [5:0] seconds, minutes, al_minutes;
    logic [3:0] hours, al_hours;
    logic       al_on, alarm, dropped;

    timekeep_scheduler #(
        .AL_STEP        (AL_STEP),
        .HOURS_MAX      (HM),
        .ALARM_TIMEOUT_S(TIMEOUT_S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1hz  (tick_1hz),
        .sec_adj   (sec_adj),
        .min_adj   (min_adj),
        .hrs_adj   (hrs_adj),
        .al_adj    (al_adj),
        .al_toggle (al_toggle),
        .seconds   (seconds),
        .minutes   (minutes),
        .hours     (hours),
        .al_minutes(al_minutes),
        .al_hours  (al_hours),
        .al_on     (al_on),
        .alarm     (alarm),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s, m, h, am, ah;
        bit on, ring, drop;
    } snap_t;

    snap_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Model state: time as fields, alarm mode 0=off 1=armed 2=ringing.
    int       m_s, m_m, m_h, m_am, m_ah, m_mode, m_ring;
    bit       m_drop;
    bit [5:0] m_pend;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit [5:0] p, input bit r);
        int g;
        int t;
        bit eq_b, eq_a;
        if (r) begin
            m_s = 0; m_m = 0; m_h = 0; m_am = 0; m_ah = 0;
            m_mode = 0; m_ring = 0; m_drop = 0; m_pend = '0;
        end else begin
            g = -1;
            for (int i = 0; i < 6; i++) begin
                if (m_pend[i] && g < 0) g = i;
            end
            eq_b = (m_h == m_ah) && (m_m == m_am);
            case (g)
                0: begin
                    t = (m_h * 3600 + m_m * 60 + m_s + 1) % (HM * 3600);
                    m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
                end
                1: m_s = (m_s + 1) % 60;
                2: m_m = (m_m + 1) % 60;
                3: m_h = (m_h + 1) % HM;
                4: begin
                    t = (m_ah * 60 + m_am + AL_STEP) % (HM * 60);
                    m_ah = t / 60; m_am = t % 60;
                end
                default: ;
            endcase
            eq_a = (m_h == m_ah) && (m_m == m_am);
            if (g == 5) begin
                m_mode = (m_mode == 0) ? 1 : 0;
            end else if (m_mode == 1 && g >= 0 && !eq_b && eq_a) begin
                m_mode = 2; m_ring = 0;
            end else if (m_mode == 2 && g == 0) begin
                m_ring++;
                if (m_ring == TIMEOUT_S) m_mode = 1;
            end
            for (int i = 0; i < 6; i++) begin
                if (p[i] && m_pend[i] && i != g) m_drop = 1;
                m_pend[i] = (m_pend[i] && i != g) || p[i];
            end
        end
        q.push_back('{s: m_s, m: m_m, h: m_h, am: m_am, ah: m_ah,
                      on: (m_mode != 0), ring: (m_mode == 2), drop: m_drop});
    endtask

    always @(negedge clk) begin
        snap_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("seconds",    int'(seconds),    e.s);
            chk("minutes",    int'(minutes),    e.m);
            chk("hours",      int'(hours),      e.h);
            chk("al_minutes", int'(al_minutes), e.am);
            chk("al_hours",   int'(al_hours),   e.ah);
            chk("al_on",      int'(al_on),      int'(e.on));
            chk("alarm",      int'(alarm),      int'(e.ring));
            chk("dropped",    int'(dropped),    int'(e.drop));
        end
    end

    // Pulse vector bit order: {tog, al, hrs, min, sec, tick}.
    task automatic step(input logic [5:0] p, input logic r);
        {al_toggle, al_adj, hrs_adj, min_adj, sec_adj, tick_1hz} = p;
        reset = r;
        @(posedge clk);
        model_edge(p, r);
        #1;
    endtask

    task automatic pulse_n(input logic [5:0] p, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(p, 1'b0);
            repeat (gap) step(6'd0, 1'b0);
        end
    endtask

    task automatic do_reset();
        step(6'd0, 1'b1);
        step(6'd0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        {al_toggle, al_adj, hrs_adj, min_adj, sec_adj, tick_1hz} = '0;
        do_reset();
        chk("reset_seconds", int'(seconds), 0);
        chk("reset_al_on",   int'(al_on),   0);

        // 60 spaced ticks roll over into the minute.
        pulse_n(6'b000001, 60, 9);
        chk("tp1_seconds", int'(seconds), 0);
        chk("tp1_minutes", int'(minutes), 1);
        chk("tp1_hours",   int'(hours),   0);
        chk("tp1_dropped", int'(dropped), 0);

        // Adjust to 11:59:59, tick wraps to 00:00:00, then minute wrap without carry.
        do_reset();
        pulse_n(6'b001000, 11, 1);
        pulse_n(6'b000100, 59, 1);
        pulse_n(6'b000010, 59, 1);
        pulse_n(6'b000001, 1, 2);
        chk("tp2_hours",   int'(hours),   0);
        chk("tp2_minutes", int'(minutes), 0);
        chk("tp2_seconds", int'(seconds), 0);
        pulse_n(6'b000100, 59, 1);
        pulse_n(6'b001000, 3, 1);
        pulse_n(6'b000100, 1, 2);
        chk("tp2_min_wrap", int'(minutes), 0);
        chk("tp2_hrs_kept", int'(hours),   3);

        // Simultaneous tick and sec_adj at 00:00:10.
        do_reset();
        pulse_n(6'b000001, 10, 2);
        step(6'b000011, 1'b0);
        step(6'd0, 1'b0);
        chk("prio_first",  int'(seconds), 11);
        step(6'd0, 1'b0);
        chk("prio_second", int'(seconds), 12);

        // Alarm minute stepping and hour carry.
        do_reset();
        pulse_n(6'b010000, 6, 1);
        chk("al_6_min", int'(al_minutes), 0);
        chk("al_6_hrs", int'(al_hours),   1);
        pulse_n(6'b010000, 6, 1);
        chk("al_12_hrs", int'(al_hours),  2);

        // Alarm at 01:00: arm, ring on the tick into 01:00:00, auto-silence, re-ring, toggle off.
        do_reset();
        pulse_n(6'b010000, 6, 1);
        pulse_n(6'b100000, 1, 2);
        chk("arm_al_on", int'(al_on), 1);
        pulse_n(6'b000100, 59, 1);
        pulse_n(6'b000010, 59, 1);
        pulse_n(6'b000001, 1, 2);
        chk("ring_alarm", int'(alarm), 1);
        pulse_n(6'b000001, 59, 3);
        chk("ring_59_still", int'(alarm), 1);
        pulse_n(6'b000001, 1, 3);
        chk("timeout_alarm", int'(alarm), 0);
        chk("timeout_al_on", int'(al_on), 1);
        pulse_n(6'b000100, 59, 1);
        chk("rering_alarm", int'(alarm), 1);
        pulse_n(6'b100000, 1, 2);
        chk("tog_alarm", int'(alarm), 0);
        chk("tog_al_on", int'(al_on), 0);

        // Coalescing: hrs_adj re-pulsed while still pending behind the tick.
        do_reset();
        step(6'b001101, 1'b0);
        step(6'b001000, 1'b0);
        repeat (6) step(6'd0, 1'b0);
        chk("drop_flag",  int'(dropped), 1);
        chk("drop_hours", int'(hours),   1);
        do_reset();
        chk("drop_clear", int'(dropped), 0);

        // Random traffic with occasional resets, checked only by the scoreboard.
        for (int c = 0; c < 4000; c++) begin
            logic [5:0] p;
            for (int i = 0; i < 6; i++) p[i] = ($urandom_range(0, 4) == 0);
            step(p, $urandom_range(0, 499) == 0);
        end
        repeat (8) step(6'd0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
